decode: RTL and testbench

- Decode stage directly downstream of the fetch unit; consumes the fetched 32-bit RV32I command word and its PC.
- Splits the word into register indices, immediate and control flags, and reads both source operands from the register file.
- Hands a latched decode bundle to execute using the same enable/done handshake that fetch uses.

---
 rtl/decode.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_decode.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// -----------------------------------------------------------------------------
// decode: RV32I decode stage between fetch and execute.
//
// Takes one fetched command word and its PC per enable pulse, reads both source
// operands from the register file, and presents a registered decode bundle with
// a one-cycle done pulse two cycles after enable.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   enable / done       start pulse from fetch / completion pulse to execute
//   command, pc         instruction word and its PC (sampled on enable)
//   rs1_addr, rs2_addr  register file read addresses (from the latched word)
//   rs1_data, rs2_data  register file read data
//   pc_out, rd, funct3  latched PC and instruction fields
//   alu_op, imm         ALU operation code and sign-extended immediate
//   op1, op2            ALU operands
//   use_imm .. is_jalr  control flags
//   illegal             unrecognised opcode / funct encoding
//
// Configuration
//   DECODE_RV32M_EN     when defined, OP with funct7=0000001 decodes as the
//                       M-extension class (alu_op 10); otherwise it is illegal.
// -----------------------------------------------------------------------------
module decode #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  done,
    input  logic [31:0]           command,
    input  logic [XLEN-1:0]       pc,
    output logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    output logic [XLEN-1:0]       pc_out,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [2:0]            funct3,
    output logic [3:0]            alu_op,
    output logic [XLEN-1:0]       imm,
    output logic [XLEN-1:0]       op1,
    output logic [XLEN-1:0]       op2,
    output logic                  use_imm,
    output logic                  reg_write,
    output logic                  is_load,
    output logic                  is_store,
    output logic                  is_branch,
    output logic                  is_jal,
    output logic                  is_jalr,
    output logic                  illegal
);

    // Major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef DECODE_RV32M_EN
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [3:0] ALU_MUL   = 4'd10;
`endif

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP1_RS1,
        OP1_ZERO,
        OP1_PC
    } op1_sel_t;

    state_t          state;
    logic [31:0]     cmd_q;
    logic [XLEN-1:0] pc_q;

    // Instruction fields of the latched word
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd_f;

    assign opcode = cmd_q[6:0];
    assign f3     = cmd_q[14:12];
    assign f7     = cmd_q[31:25];
    assign rd_f   = cmd_q[11:7];

    // Register file addresses come straight from the latched word so the read
    // data is settled by the end of READ.
    assign rs1_addr = REG_ADDR_W'(cmd_q[19:15]);
    assign rs2_addr = REG_ADDR_W'(cmd_q[24:20]);

    // Immediate formats
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{cmd_q[31]}}, cmd_q[31:20]};
    assign imm_s = {{20{cmd_q[31]}}, cmd_q[31:25], cmd_q[11:7]};
    assign imm_b = {{19{cmd_q[31]}}, cmd_q[31], cmd_q[7], cmd_q[30:25], cmd_q[11:8], 1'b0};
    assign imm_u = {cmd_q[31:12], 12'b0};
    assign imm_j = {{11{cmd_q[31]}}, cmd_q[31], cmd_q[19:12], cmd_q[20], cmd_q[30:21], 1'b0};

    // Register/immediate arithmetic op from funct3; alt picks SUB/SRA.
    function automatic logic [3:0] alu_map(input logic [2:0] fn3, input logic alt);
        logic [3:0] op;
        case (fn3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Decoded bundle of the latched word, registered during READ
    logic        d_illegal;
    logic        d_use_imm;
    logic        d_reg_write;
    logic        d_is_load;
    logic        d_is_store;
    logic        d_is_branch;
    logic        d_is_jal;
    logic        d_is_jalr;
    logic [3:0]  d_alu;
    logic [31:0] d_imm;
    op1_sel_t    d_op1_sel;

    // Opcode / funct decode
    always_comb begin
        d_illegal   = 1'b0;
        d_use_imm   = 1'b0;
        d_reg_write = 1'b0;
        d_is_load   = 1'b0;
        d_is_store  = 1'b0;
        d_is_branch = 1'b0;
        d_is_jal    = 1'b0;
        d_is_jalr   = 1'b0;
        d_alu       = ALU_ADD;
        d_imm       = '0;
        d_op1_sel   = OP1_RS1;

        case (opcode)
            OPC_LUI: begin
                d_reg_write = 1'b1;
                d_use_imm   = 1'b1;
                d_imm       = imm_u;
                d_op1_sel   = OP1_ZERO;
            end
            OPC_AUIPC: begin
                d_reg_write = 1'b1;
                d_use_imm   = 1'b1;
                d_imm       = imm_u;
                d_op1_sel   = OP1_PC;
            end
            OPC_JAL: begin
                d_is_jal    = 1'b1;
                d_reg_write = 1'b1;
                d_use_imm   = 1'b1;
                d_imm       = imm_j;
                d_op1_sel   = OP1_PC;
            end
            OPC_JALR: begin
                d_is_jalr   = 1'b1;
                d_reg_write = 1'b1;
                d_use_imm   = 1'b1;
                d_imm       = imm_i;
                d_illegal   = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                d_is_branch = 1'b1;
                d_alu       = ALU_SUB;
                d_imm       = imm_b;
                d_illegal   = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                d_is_load   = 1'b1;
                d_reg_write = 1'b1;
                d_use_imm   = 1'b1;
                d_imm       = imm_i;
                d_illegal   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                d_is_store  = 1'b1;
                d_use_imm   = 1'b1;
                d_imm       = imm_s;
                d_illegal   = (f3 > 3'b010);
            end
            OPC_OP_IMM: begin
                d_reg_write = 1'b1;
                d_use_imm   = 1'b1;
                d_imm       = imm_i;
                // Bit 30 is immediate data except on right shifts, so only
                // funct3=101 may select the arithmetic variant.
                d_alu       = alu_map(f3, (f3 == 3'b101) && f7[5]);
                if (f3 == 3'b001) begin
                    d_illegal = (f7 != F7_BASE);
                end else if (f3 == 3'b101) begin
                    d_illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
                end
            end
            OPC_OP: begin
                d_reg_write = 1'b1;
                if (f7 == F7_BASE) begin
                    d_alu = alu_map(f3, 1'b0);
                end else if ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))) begin
                    d_alu = alu_map(f3, 1'b1);
`ifdef DECODE_RV32M_EN
                end else if (f7 == F7_MULDIV) begin
                    d_alu = ALU_MUL;
`endif
                end else begin
                    d_illegal = 1'b1;
                end
            end
            default: d_illegal = 1'b1;
        endcase

        // An illegal word carries no control side effects.
        if (d_illegal) begin
            d_use_imm   = 1'b0;
            d_reg_write = 1'b0;
            d_is_load   = 1'b0;
            d_is_store  = 1'b0;
            d_is_branch = 1'b0;
            d_is_jal    = 1'b0;
            d_is_jalr   = 1'b0;
            d_alu       = ALU_ADD;
            d_op1_sel   = OP1_RS1;
        end

        // Writes to x0 are dropped here so execute never has to check.
        if (rd_f == 5'd0) begin
            d_reg_write = 1'b0;
        end
    end

    // Control FSM and registered decode bundle
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cmd_q     <= '0;
            pc_q      <= '0;
            done      <= 1'b0;
            pc_out    <= '0;
            rd        <= '0;
            funct3    <= '0;
            alu_op    <= '0;
            imm       <= '0;
            op1       <= '0;
            op2       <= '0;
            use_imm   <= 1'b0;
            reg_write <= 1'b0;
            is_load   <= 1'b0;
            is_store  <= 1'b0;
            is_branch <= 1'b0;
            is_jal    <= 1'b0;
            is_jalr   <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        cmd_q <= command;
                        pc_q  <= pc;
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    pc_out    <= pc_q;
                    rd        <= REG_ADDR_W'(rd_f);
                    funct3    <= f3;
                    alu_op    <= d_alu;
                    imm       <= XLEN'($signed(d_imm));
                    use_imm   <= d_use_imm;
                    reg_write <= d_reg_write;
                    is_load   <= d_is_load;
                    is_store  <= d_is_store;
                    is_branch <= d_is_branch;
                    is_jal    <= d_is_jal;
                    is_jalr   <= d_is_jalr;
                    illegal   <= d_illegal;
                    case (d_op1_sel)
                        OP1_ZERO: op1 <= '0;
                        OP1_PC:   op1 <= pc_q;
                        default:  op1 <= rs1_data;
                    endcase
                    op2   <= d_use_imm ? XLEN'($signed(d_imm)) : rs2_data;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode.sv
// -----------------------------------------------------------------------------
// tb_decode: scoreboard bench for the decode stage. Stimulus pushes a predicted
// decode bundle per accepted command; a monitor pops and compares on each done.
// -----------------------------------------------------------------------------
module tb_decode;

`ifdef DECODE_RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        done;
    logic [31:0] command = '0;
    logic [31:0] pc = '0;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] pc_out, imm, op1, op2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        use_imm, reg_write, is_load, is_store, is_branch, is_jal, is_jalr, illegal;

    logic [31:0] regs [32];
    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    decode dut (
        .clk(clk), .reset(reset), .enable(enable), .done(done),
        .command(command), .pc(pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .pc_out(pc_out), .rd(rd), .funct3(funct3), .alu_op(alu_op),
        .imm(imm), .op1(op1), .op2(op2),
        .use_imm(use_imm), .reg_write(reg_write), .is_load(is_load),
        .is_store(is_store), .is_branch(is_branch), .is_jal(is_jal),
        .is_jalr(is_jalr), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] pc_out, imm, op1, op2;
        logic [4:0]  rd, rs1a, rs2a;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        use_imm, rw, ld, st, br, jal, jalr, ill;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    // Reference decode written from the ISA rules with plain arithmetic.
    function automatic exp_t predict(input logic [31:0] c, input logic [31:0] p,
                                     input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        logic legal, writes;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        int arith [8];
        int iv, sv, bv, jv;
        arith = '{0, 2, 3, 4, 5, 6, 8, 9};
        opc = c[6:0]; f3 = c[14:12]; f7 = c[31:25];
        iv = $signed(c) >>> 20;
        sv = ($signed(c) >>> 25) * 32 + int'(c[11:7]);
        bv = (c[31] ? -4096 : 0) + int'(c[7]) * 2048 + int'(c[30:25]) * 32 + int'(c[11:8]) * 2;
        jv = (c[31] ? -1048576 : 0) + int'(c[19:12]) * 4096 + int'(c[20]) * 2048 + int'(c[30:21]) * 2;
        e.rd = c[11:7]; e.rs1a = c[19:15]; e.rs2a = c[24:20]; e.f3 = f3;
        e.pc_out = p; e.op1 = r1; e.imm = '0; e.alu = '0;
        e.use_imm = 0; e.rw = 0; e.ld = 0; e.st = 0; e.br = 0; e.jal = 0; e.jalr = 0;
        e.cyc = 0;
        legal = 1; writes = 0;
        case (opc)
            7'h37: begin writes = 1; e.use_imm = 1; e.imm = c & 32'hFFFFF000; e.op1 = 0; end
            7'h17: begin writes = 1; e.use_imm = 1; e.imm = c & 32'hFFFFF000; e.op1 = p; end
            7'h6F: begin writes = 1; e.use_imm = 1; e.jal = 1; e.imm = 32'(jv); e.op1 = p; end
            7'h67: begin writes = 1; e.use_imm = 1; e.jalr = 1; e.imm = 32'(iv); legal = (f3 == 3'd0); end
            7'h63: begin e.br = 1; e.alu = 1; e.imm = 32'(bv); legal = !(f3 inside {3'd2, 3'd3}); end
            7'h03: begin writes = 1; e.use_imm = 1; e.ld = 1; e.imm = 32'(iv);
                         legal = !(f3 inside {3'd3, 3'd6, 3'd7}); end
            7'h23: begin e.use_imm = 1; e.st = 1; e.imm = 32'(sv); legal = (f3 <= 3'd2); end
            7'h13: begin
                writes = 1; e.use_imm = 1; e.imm = 32'(iv); e.alu = 4'(arith[f3]);
                if (f3 == 3'd1) legal = (f7 == 7'h00);
                if (f3 == 3'd5) begin
                    legal = (f7 inside {7'h00, 7'h20});
                    if (f7 == 7'h20) e.alu = 4'd7;
                end
            end
            7'h33: begin
                writes = 1;
                if (f7 == 7'h00) e.alu = 4'(arith[f3]);
                else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 4'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'd7;
                else if (f7 == 7'h01 && M_EN) e.alu = 4'd10;
                else legal = 0;
            end
            default: legal = 0;
        endcase
        e.op2 = e.use_imm ? e.imm : r2;
        e.ill = !legal;
        if (!legal) begin
            e.use_imm = 0; e.ld = 0; e.st = 0; e.br = 0; e.jal = 0; e.jalr = 0;
        end
        e.rw = writes && legal && (e.rd != 5'd0);
        return e;
    endfunction

    // Monitor: every done must match the oldest prediction
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("latency", 32'(cyc), 32'(e.cyc));
                chk("pc_out", pc_out, e.pc_out);
                chk("rd", 32'(rd), 32'(e.rd));
                chk("rs1_addr", 32'(rs1_addr), 32'(e.rs1a));
                chk("rs2_addr", 32'(rs2_addr), 32'(e.rs2a));
                chk("funct3", 32'(funct3), 32'(e.f3));
                chk("illegal", 32'(illegal), 32'(e.ill));
                chk("flags", {25'd0, use_imm, reg_write, is_load, is_store, is_branch, is_jal, is_jalr},
                    {25'd0, e.use_imm, e.rw, e.ld, e.st, e.br, e.jal, e.jalr});
                if (!e.ill) begin
                    chk("alu_op", 32'(alu_op), 32'(e.alu));
                    chk("imm", imm, e.imm);
                    chk("op1", op1, e.op1);
                    chk("op2", op2, e.op2);
                end
            end
        end
    end

    // mode 0: single pulse; 1: enable held into READ; 2: extra pulse in DONE
    task automatic run_one(input logic [31:0] c, input logic [31:0] p, input int mode);
        exp_t e;
        bit seen;
        @(negedge clk);
        e = predict(c, p, regs[c[19:15]], regs[c[24:20]]);
        e.cyc = cyc + 2;
        exp_q.push_back(e);
        enable = 1'b1; command = c; pc = p;
        @(negedge clk);
        if (mode == 1) begin
            command = $urandom; pc = $urandom;
            @(negedge clk);
        end
        enable = 1'b0;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (done) seen = 1;
            else @(negedge clk);
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (!seen && exp_q.size() != 0) void'(exp_q.pop_front());
        if (seen && mode == 2) begin
            enable = 1'b1; command = $urandom; pc = $urandom;
            @(negedge clk);
            enable = 1'b0;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pc_out"}, pc_out, 32'd0);
        chk({tag, "_imm"}, imm, 32'd0);
        chk({tag, "_op1"}, op1, 32'd0);
        chk({tag, "_op2"}, op2, 32'd0);
        chk({tag, "_fields"}, {10'd0, rd, rs1_addr, rs2_addr, funct3, alu_op},
            32'd0);
        chk({tag, "_flags"}, {24'd0, use_imm, reg_write, is_load, is_store, is_branch,
                              is_jal, is_jalr, illegal}, 32'd0);
    endtask

    function automatic logic [31:0] rand_cmd();
        logic [31:0] c;
        logic [6:0] ops [9];
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        c = $urandom;
        if ($urandom_range(0, 7) != 0) c[6:0] = ops[$urandom_range(0, 8)];
        if (c[6:0] inside {7'h13, 7'h33}) begin
            case ($urandom_range(0, 3))
                0: c[31:25] = 7'h00;
                1: c[31:25] = 7'h20;
                2: c[31:25] = 7'h01;
                default: ;
            endcase
        end
        return c;
    endfunction

    task automatic rand_regs();
        regs[0] = '0;
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rand_regs();
        repeat (3) @(negedge clk);
        check_outputs_zero("init");
        reset = 1'b0;

        // ADDI x5,x1,-3 with enable held into READ (second pulse ignored)
        regs[1] = 32'd10;
        run_one(32'hFFD08293, 32'h0000_0040, 1);
        chk("addi_imm", imm, 32'hFFFFFFFD);
        chk("addi_op1", op1, 32'd10);
        chk("addi_op2", op2, 32'hFFFFFFFD);
        chk("addi_rd", 32'(rd), 32'd5);
        chk("addi_rs1", 32'(rs1_addr), 32'd1);

        // SUB x3,x2,x1
        regs[2] = 32'd7; regs[1] = 32'd2;
        run_one(32'h401101B3, 32'h0000_0044, 0);
        chk("sub_alu", 32'(alu_op), 32'd1);
        chk("sub_ops", {op1[15:0], op2[15:0]}, {16'd7, 16'd2});

        // BEQ x1,x2,-8 at 0x100
        run_one(32'hFE208CE3, 32'h0000_0100, 2);
        chk("beq_imm", imm, 32'hFFFFFFF8);
        chk("beq_br_rw", {30'd0, is_branch, reg_write}, 32'd2);
        chk("beq_pc", pc_out, 32'h100);

        // JAL x0,+2048 then an unknown opcode
        run_one(32'h0010006F, 32'h0000_0200, 0);
        chk("jal_flags", {30'd0, is_jal, reg_write}, 32'd2);
        chk("jal_imm", imm, 32'h800);
        run_one(32'h0000007F, 32'h0000_0204, 0);
        chk("bad_op_illegal", 32'(illegal), 32'd1);
        chk("bad_op_flags", {25'd0, use_imm, reg_write, is_load, is_store, is_branch,
                             is_jal, is_jalr}, 32'd0);

        // MUL x1,x2,x3
        run_one(32'h023100B3, 32'h0000_0208, 0);
        chk("mul_illegal", 32'(illegal), M_EN ? 32'd0 : 32'd1);

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            rand_regs();
            run_one(rand_cmd(), $urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 3)) % 3);
        end

        // Reset while a decode is in READ: abandoned, no done, outputs cleared
        rand_regs();
        @(negedge clk);
        enable = 1'b1; command = 32'hFFD08293; pc = 32'h300;
        @(negedge clk);
        enable = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("abandoned_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        check_outputs_zero("post_reset");

        // Recovery after reset
        run_one(32'h401101B3, 32'h0000_0400, 0);

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
